core_cache_sram_ctrl: RTL

Controller that owns one `core_cache_sram` instance and shares it between two cache-side read requesters and one line-fill writer. After reset, and on each flush request, it sweeps the whole array to zero so valid/tag bits start cleared. In normal operation it round-robins the single read port, tracks the 1-cycle SRAM read latency, and routes returned data to the granted requester, with same-cycle write-to-read forwarding.

---
 rtl/core_cache_pkg.sv | 12 +
 rtl/core_cache_sram.sv | 26 ++
 rtl/core_cache_sram_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/core_cache_pkg.sv
// Shared types for the cache SRAM controller: FSM states and read-port indices.
package core_cache_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic RD0 = 1'b0;
  localparam logic RD1 = 1'b1;

endpackage

// File: rtl/core_cache_sram.sv
// Simple dual-port SRAM: one write port, one registered read port (1-cycle latency).
// A read and a write to the same address in one cycle return the old contents.
module core_cache_sram #(
  parameter int width   = 32,
  parameter int widthad = 6
) (
  input  logic               clk,
  input  logic               we,
  input  logic [widthad-1:0] waddr,
  input  logic [width-1:0]   wdata,
  input  logic               re,
  input  logic [widthad-1:0] raddr,
  output logic [width-1:0]   rdata
);

  logic [width-1:0] mem_q [2**widthad];
  logic [width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/core_cache_sram_ctrl.sv
// Shares one cache SRAM between two round-robin readers and a line-fill writer,
// zeroing the whole array after reset and on flush.
//   state | meaning
//   INIT  | sweeping zeros into every address, no handshakes accepted
//   RUN   | normal read arbitration and line-fill writes
module core_cache_sram_ctrl
  import core_cache_pkg::*;
#(
  parameter int width   = 32,
  parameter int widthad = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  output logic               init_busy,
  input  logic               rd0_valid,
  input  logic [widthad-1:0] rd0_addr,
  output logic               rd0_ready,
  output logic               rd0_rvalid,
  output logic [width-1:0]   rd0_data,
  input  logic               rd1_valid,
  input  logic [widthad-1:0] rd1_addr,
  output logic               rd1_ready,
  output logic               rd1_rvalid,
  output logic [width-1:0]   rd1_data,
  input  logic               wr_valid,
  input  logic [widthad-1:0] wr_addr,
  input  logic [width-1:0]   wr_data,
  output logic               wr_ready
);

  state_e             state_q, state_d;
  logic [widthad-1:0] cnt_q, cnt_d;
  logic               prefer_q, prefer_d;
  logic               rvalid_q, rvalid_d;
  logic               rport_q, rport_d;
  logic               fwd_q, fwd_d;
  logic [width-1:0]   fwd_data_q, fwd_data_d;
  logic [width-1:0]   rd0_hold_q, rd0_hold_d;
  logic [width-1:0]   rd1_hold_q, rd1_hold_d;

  logic               grant, gport;
  logic               sram_we;
  logic [widthad-1:0] sram_waddr, sram_raddr;
  logic [width-1:0]   sram_wdata, sram_rdata, rdata_sel;

  core_cache_sram #(.width(width), .widthad(widthad)) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .waddr (sram_waddr),
    .wdata (sram_wdata),
    .re    (grant),
    .raddr (sram_raddr),
    .rdata (sram_rdata)
  );

  // The SRAM is read-first, so a same-cycle write hit is replayed from a side register.
  assign rdata_sel  = fwd_q ? fwd_data_q : sram_rdata;
  assign init_busy  = (state_q == INIT);
  assign rd0_rvalid = rvalid_q && (rport_q == RD0);
  assign rd1_rvalid = rvalid_q && (rport_q == RD1);
  assign rd0_data   = rd0_rvalid ? rdata_sel : rd0_hold_q;
  assign rd1_data   = rd1_rvalid ? rdata_sel : rd1_hold_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prefer_d   = prefer_q;
    grant      = 1'b0;
    gport      = RD0;
    rd0_ready  = 1'b0;
    rd1_ready  = 1'b0;
    wr_ready   = 1'b0;
    sram_we    = 1'b0;
    sram_waddr = cnt_q;
    sram_wdata = '0;
    sram_raddr = rd0_addr;
    fwd_d      = 1'b0;
    fwd_data_d = wr_data;
    rd0_hold_d = rd0_rvalid ? rdata_sel : rd0_hold_q;
    rd1_hold_d = rd1_rvalid ? rdata_sel : rd1_hold_q;

    case (state_q)
      INIT: begin
        sram_we = 1'b1;
        cnt_d   = cnt_q + widthad'(1);
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: begin
        wr_ready   = 1'b1;
        sram_we    = wr_valid;
        sram_waddr = wr_addr;
        sram_wdata = wr_data;
        if (rd0_valid && rd1_valid) begin
          grant = 1'b1;
          gport = prefer_q;
        end else if (rd0_valid) begin
          grant = 1'b1;
          gport = RD0;
        end else if (rd1_valid) begin
          grant = 1'b1;
          gport = RD1;
        end
        if (grant) begin
          prefer_d  = ~gport;
          rd0_ready = (gport == RD0);
          rd1_ready = (gport == RD1);
        end
        sram_raddr = (gport == RD1) ? rd1_addr : rd0_addr;
        fwd_d      = grant && wr_valid && (wr_addr == sram_raddr);
        if (flush) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      prefer_q   <= RD0;
      rvalid_q   <= 1'b0;
      rport_q    <= RD0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      rd0_hold_q <= '0;
      rd1_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prefer_q   <= prefer_d;
      rvalid_q   <= rvalid_d;
      rport_q    <= rport_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      rd0_hold_q <= rd0_hold_d;
      rd1_hold_q <= rd1_hold_d;
    end
  end

  assign rvalid_d = grant;
  assign rport_d  = gport;

endmodule
